exception_sequencer: RTL and testbench

- Multicycle sequencer that acts on a raised exception: saves the faulting PC into EPC, reads the handler-address byte from the exception vector slot (253/254/255), and loads the zero-extended byte into PC.
- Consumes the exception flag and vector address produced by the exception-control logic.
- Stalls the main control unit while it owns the EPC, PC and memory-read paths.

---
 rtl/exception_sequencer.sv | 137 +++++++++++++
 tb/tb_exception_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// exception_sequencer: on a raised exception, saves the faulting PC into EPC,
// fetches the handler byte from the exception vector slot and loads it into PC.
// The main control unit is stalled (busy_o) while the sequence runs.
// Optional feature: define EXC_CAUSE_REG_EN to build the latched cause_o register;
// without it cause_o is tied to 2'b00.
//
// state    | meaning
// IDLE     | waiting for a non-spurious exception request
// SAVE_EPC | write faulting PC minus PC_DEC into EPC
// MEM_REQ  | issue the vector-slot read, arm the latency counter
// MEM_WAIT | wait out the memory latency, capture the handler byte
// LOAD_PC  | write the zero-extended handler byte into PC
module exception_sequencer #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] PC_DEC      = 32'd4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        exc_req_i,
  input  logic [31:0] mem_position_i,
  input  logic [31:0] pc_current_i,
  input  logic [31:0] mem_rdata_i,
  output logic        exc_ack_o,
  output logic        busy_o,
  output logic        epc_wr_o,
  output logic [31:0] epc_data_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  output logic        pc_wr_o,
  output logic [31:0] pc_data_o,
  output logic        done_o,
  output logic [1:0]  cause_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_EPC = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    LOAD_PC  = 3'd4
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] epc_q;
  logic [31:0] mem_addr_q;
  logic [7:0]  vec_q;
  logic        accept;
  logic        unused_rdata;

  // Only the low byte of the vector slot is a handler address.
  assign unused_rdata = ^mem_rdata_i[31:8];

  // A zero vector address means the request is spurious and is dropped.
  assign accept = (state_q == IDLE) && exc_req_i && (mem_position_i != 32'd0);

  // State and latency counter registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = SAVE_EPC;
      SAVE_EPC: state_d = MEM_REQ;
      MEM_REQ: begin
        cnt_d   = LAT_M1;
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (cnt_q == 4'd0) state_d = LOAD_PC;
        else               cnt_d   = cnt_q - 4'd1;
      end
      LOAD_PC:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Request capture and data-output holding registers. EPC is formed at
  // acceptance so it is already stable during SAVE_EPC; mem_addr only moves
  // when a new read is about to issue, so it holds between sequences.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q     <= 32'd0;
      epc_q      <= 32'd0;
      mem_addr_q <= 32'd0;
      vec_q      <= 8'd0;
    end else begin
      if (accept) begin
        addr_q <= mem_position_i;
        epc_q  <= pc_current_i - PC_DEC;
      end
      if (state_q == SAVE_EPC) mem_addr_q <= addr_q;
      if ((state_q == MEM_WAIT) && (cnt_q == 4'd0)) vec_q <= mem_rdata_i[7:0];
    end
  end

`ifdef EXC_CAUSE_REG_EN
  logic [1:0] cause_q;

  // Cause is the low two bits of the vector slot, kept until the next accept.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  cause_q <= 2'b00;
    else if (accept) cause_q <= mem_position_i[1:0];
  end

  assign cause_o = cause_q;
`else
  assign cause_o = 2'b00;
`endif

  // Control strobes decode from state; data outputs come from holding registers.
  always_comb begin
    exc_ack_o  = accept;
    busy_o     = (state_q != IDLE);
    epc_wr_o   = (state_q == SAVE_EPC);
    mem_rd_o   = (state_q == MEM_REQ);
    pc_wr_o    = (state_q == LOAD_PC);
    done_o     = (state_q == LOAD_PC);
    epc_data_o = epc_q;
    mem_addr_o = mem_addr_q;
    pc_data_o  = {24'd0, vec_q};
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: two instances (latency 1 and latency 3)
// sharing reset and request data, each with its own vector-slot memory model.
module tb_exception_sequencer;

  logic        clk;
  logic        reset_n;
  logic        exc_req1, exc_req3;
  logic [31:0] mem_position;
  logic [31:0] pc_current;

  logic        ack1, busy1, epc_wr1, mem_rd1, pc_wr1, done1;
  logic [31:0] epc_data1, mem_addr1, pc_data1, mem_rdata1;
  logic [1:0]  cause1;
  logic        ack3, busy3, epc_wr3, mem_rd3, pc_wr3, done3;
  logic [31:0] epc_data3, mem_addr3, pc_data3, mem_rdata3;
  logic [1:0]  cause3;

  int n_checks = 0;
  int n_fail   = 0;
  logic sel = 1'b0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'd253: return 32'hDEADBE40;
      32'd254: return 32'hCAFEF055;
      32'd255: return 32'hFFFFFF7C;
      default: return 32'h12345699;
    endcase
  endfunction

  assign mem_rdata1 = mem_read(mem_addr1);
  assign mem_rdata3 = mem_read(mem_addr3);

  exception_sequencer #(.MEM_LATENCY(1), .PC_DEC(32'd4)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .exc_req_i(exc_req1),
    .mem_position_i(mem_position), .pc_current_i(pc_current), .mem_rdata_i(mem_rdata1),
    .exc_ack_o(ack1), .busy_o(busy1), .epc_wr_o(epc_wr1), .epc_data_o(epc_data1),
    .mem_rd_o(mem_rd1), .mem_addr_o(mem_addr1), .pc_wr_o(pc_wr1), .pc_data_o(pc_data1),
    .done_o(done1), .cause_o(cause1)
  );

  exception_sequencer #(.MEM_LATENCY(3), .PC_DEC(32'd4)) dut3 (
    .clk_i(clk), .reset_n_i(reset_n), .exc_req_i(exc_req3),
    .mem_position_i(mem_position), .pc_current_i(pc_current), .mem_rdata_i(mem_rdata3),
    .exc_ack_o(ack3), .busy_o(busy3), .epc_wr_o(epc_wr3), .epc_data_o(epc_data3),
    .mem_rd_o(mem_rd3), .mem_addr_o(mem_addr3), .pc_wr_o(pc_wr3), .pc_data_o(pc_data3),
    .done_o(done3), .cause_o(cause3)
  );

  logic        v_ack, v_busy, v_epc_wr, v_mem_rd, v_pc_wr, v_done;
  logic [31:0] v_epc_data, v_mem_addr, v_pc_data;
  logic [1:0]  v_cause;
  assign v_ack      = sel ? ack3      : ack1;
  assign v_busy     = sel ? busy3     : busy1;
  assign v_epc_wr   = sel ? epc_wr3   : epc_wr1;
  assign v_mem_rd   = sel ? mem_rd3   : mem_rd1;
  assign v_pc_wr    = sel ? pc_wr3    : pc_wr1;
  assign v_done     = sel ? done3     : done1;
  assign v_epc_data = sel ? epc_data3 : epc_data1;
  assign v_mem_addr = sel ? mem_addr3 : mem_addr1;
  assign v_pc_data  = sel ? pc_data3  : pc_data1;
  assign v_cause    = sel ? cause3    : cause1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_cause(input logic [31:0] pos);
`ifdef EXC_CAUSE_REG_EN
    return pos[1:0];
`else
    return 2'b00;
`endif
  endfunction

  // One full exception sequence with a per-cycle check of every output.
  task automatic run_seq(input bit which, input int lat, input logic [31:0] pos,
                         input logic [31:0] pc, input logic [31:0] exp_epc,
                         input logic [7:0] exp_vec, input bit hold,
                         input logic [31:0] new_pos);
    sel = which;
    @(negedge clk);
    if (which) exc_req3 = 1'b1; else exc_req1 = 1'b1;
    mem_position = pos;
    pc_current   = pc;
    #1;
    chk("accept_ack", 32'(v_ack), 32'd1);
    chk("accept_busy", 32'(v_busy), 32'd0);
    for (int k = 1; k <= 3 + lat; k++) begin
      @(negedge clk);
      #1;
      chk("busy", 32'(v_busy), 32'd1);
      chk("ack_low", 32'(v_ack), 32'd0);
      chk("epc_wr", 32'(v_epc_wr), 32'(k == 1));
      chk("mem_rd", 32'(v_mem_rd), 32'(k == 2));
      chk("pc_wr", 32'(v_pc_wr), 32'(k == 3 + lat));
      chk("done", 32'(v_done), 32'(k == 3 + lat));
      chk("epc_data", v_epc_data, exp_epc);
      chk("cause", 32'(v_cause), 32'(exp_cause(pos)));
      if (k >= 2) chk("mem_addr", v_mem_addr, pos);
      if (k == 3 + lat) chk("pc_data", v_pc_data, {24'd0, exp_vec});
      if (!hold && k == 1) begin
        exc_req1 = 1'b0;
        exc_req3 = 1'b0;
      end
      if (hold && k == 3) begin
        mem_position = new_pos;
        pc_current   = pc + 32'h10;
      end
    end
    if (!hold) begin
      @(negedge clk);
      #1;
      chk("idle_busy", 32'(v_busy), 32'd0);
      chk("idle_ack", 32'(v_ack), 32'd0);
      chk("idle_pc_wr", 32'(v_pc_wr), 32'd0);
      chk("idle_pc_data", v_pc_data, {24'd0, exp_vec});
    end
  endtask

  typedef struct {
    logic [31:0] pos;
    logic [31:0] pc;
    logic [31:0] exp_epc;
    logic [7:0]  exp_vec;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{pos: 32'd253, pc: 32'h0000_0104, exp_epc: 32'h0000_0100, exp_vec: 8'h40};
    tbl[1] = '{pos: 32'd254, pc: 32'h0000_1000, exp_epc: 32'h0000_0FFC, exp_vec: 8'h55};
    tbl[2] = '{pos: 32'd255, pc: 32'h0000_0008, exp_epc: 32'h0000_0004, exp_vec: 8'h7C};
    tbl[3] = '{pos: 32'd253, pc: 32'h0000_0002, exp_epc: 32'hFFFF_FFFE, exp_vec: 8'h40};
    tbl[4] = '{pos: 32'd254, pc: 32'hFFFF_FFFF, exp_epc: 32'hFFFF_FFFB, exp_vec: 8'h55};

    reset_n      = 1'b0;
    exc_req1     = 1'b0;
    exc_req3     = 1'b0;
    mem_position = 32'd0;
    pc_current   = 32'd0;
    #12;
    chk("rst_busy", 32'(busy1 | busy3), 32'd0);
    chk("rst_strobes", 32'({ack1, epc_wr1, mem_rd1, pc_wr1, done1,
                            ack3, epc_wr3, mem_rd3, pc_wr3, done3}), 32'd0);
    chk("rst_epc_data", epc_data1 | epc_data3, 32'd0);
    chk("rst_mem_addr", mem_addr1 | mem_addr3, 32'd0);
    chk("rst_pc_data", pc_data1 | pc_data3, 32'd0);
    chk("rst_cause", 32'(cause1 | cause3), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Table-driven single sequences on the latency-1 instance.
    for (int i = 0; i < 5; i++)
      run_seq(1'b0, 1, tbl[i].pos, tbl[i].pc, tbl[i].exp_epc, tbl[i].exp_vec, 1'b0, 32'd0);

    // Latency-3 instance: pc_wr six cycles after acceptance, busy for six cycles.
    run_seq(1'b1, 3, 32'd255, 32'h0000_0050, 32'h0000_004C, 8'h7C, 1'b0, 32'd0);
    run_seq(1'b1, 3, 32'd253, 32'h0000_0000, 32'hFFFF_FFFC, 8'h40, 1'b0, 32'd0);

    // Spurious request is ignored.
    sel = 1'b0;
    @(negedge clk);
    exc_req1     = 1'b1;
    mem_position = 32'd0;
    pc_current   = 32'h0000_0AA0;
    #1;
    chk("spurious_ack", 32'(ack1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("spurious_busy", 32'(busy1), 32'd0);
      chk("spurious_epc_wr", 32'(epc_wr1), 32'd0);
    end
    exc_req1 = 1'b0;

    // EPC wrap from pc_current = 0.
    run_seq(1'b0, 1, 32'd254, 32'h0000_0000, 32'hFFFF_FFFC, 8'h55, 1'b0, 32'd0);

    // Held request: position changes mid-wait, second acceptance is immediate.
    run_seq(1'b0, 1, 32'd254, 32'h0000_0200, 32'h0000_01FC, 8'h55, 1'b1, 32'd255);
    run_seq(1'b0, 1, 32'd255, 32'h0000_0210, 32'h0000_020C, 8'h7C, 1'b0, 32'd0);

    // Reset during MEM_WAIT aborts the sequence.
    sel = 1'b0;
    @(negedge clk);
    exc_req1     = 1'b1;
    mem_position = 32'd253;
    pc_current   = 32'h0000_0300;
    #1;
    chk("abort_accept", 32'(ack1), 32'd1);
    @(negedge clk);
    exc_req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_in_wait", 32'({busy1, epc_wr1, mem_rd1, pc_wr1}), 32'b1000);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_strobes", 32'({ack1, epc_wr1, mem_rd1, pc_wr1, done1}), 32'd0);
    chk("abort_epc_data", epc_data1, 32'd0);
    chk("abort_mem_addr", mem_addr1, 32'd0);
    chk("abort_pc_data", pc_data1, 32'd0);
    chk("abort_cause", 32'(cause1), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("post_abort_idle", 32'({busy1, epc_wr1, pc_wr1, done1}), 32'd0);
    end
    run_seq(1'b0, 1, 32'd255, 32'h0000_0400, 32'h0000_03FC, 8'h7C, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
